gci_hub: RTL and testbench

//  Upstream router for four gci_node instances. Builds an address map from each node's reported MEMSIZE,

---
 rtl/gci_hub.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_gci_hub.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gci_hub.sv
`default_nettype none
// ============================================================================
//  Module      : gci_hub
//  Description : Upstream router for four gci_node instances. Builds a packed
//                address map from the reported node sizes, decodes CPU GCI
//                requests, forwards each one to the owning node with a
//                node-local address and returns the node response to the CPU.
//                Unmapped addresses receive an error response.
//                Optional macro GCI_HUB_TIMEOUT_EN adds a response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module gci_hub #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [7:0]  TIMEOUT   = 8'hFF
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   output logic        oMAP_VALID,
   // CPU side
   input  logic        iCPU_REQ,
   output logic        oCPU_BUSY,
   input  logic        iCPU_RW,
   input  logic [31:0] iCPU_ADDR,
   input  logic [31:0] iCPU_DATA,
   output logic        oCPU_REQ,
   input  logic        iCPU_BUSY,
   output logic [31:0] oCPU_DATA,
   output logic        oCPU_ERR,
   // node 0
   input  logic        iNODE0_VALID,
   input  logic        iNODE0_INFO_VALID,
   input  logic [31:0] iNODE0_MEMSIZE,
   output logic        oNODE0_REQ,
   input  logic        iNODE0_BUSY,
   output logic        oNODE0_RW,
   output logic [31:0] oNODE0_ADDR,
   output logic [31:0] oNODE0_DATA,
   input  logic        iNODE0_REQ,
   output logic        oNODE0_BUSY,
   input  logic [31:0] iNODE0_DATA,
   // node 1
   input  logic        iNODE1_VALID,
   input  logic        iNODE1_INFO_VALID,
   input  logic [31:0] iNODE1_MEMSIZE,
   output logic        oNODE1_REQ,
   input  logic        iNODE1_BUSY,
   output logic        oNODE1_RW,
   output logic [31:0] oNODE1_ADDR,
   output logic [31:0] oNODE1_DATA,
   input  logic        iNODE1_REQ,
   output logic        oNODE1_BUSY,
   input  logic [31:0] iNODE1_DATA,
   // node 2
   input  logic        iNODE2_VALID,
   input  logic        iNODE2_INFO_VALID,
   input  logic [31:0] iNODE2_MEMSIZE,
   output logic        oNODE2_REQ,
   input  logic        iNODE2_BUSY,
   output logic        oNODE2_RW,
   output logic [31:0] oNODE2_ADDR,
   output logic [31:0] oNODE2_DATA,
   input  logic        iNODE2_REQ,
   output logic        oNODE2_BUSY,
   input  logic [31:0] iNODE2_DATA,
   // node 3
   input  logic        iNODE3_VALID,
   input  logic        iNODE3_INFO_VALID,
   input  logic [31:0] iNODE3_MEMSIZE,
   output logic        oNODE3_REQ,
   input  logic        iNODE3_BUSY,
   output logic        oNODE3_RW,
   output logic [31:0] oNODE3_ADDR,
   output logic [31:0] oNODE3_DATA,
   input  logic        iNODE3_REQ,
   output logic        oNODE3_BUSY,
   input  logic [31:0] iNODE3_DATA
);

   localparam logic [2:0] ST_INIT = 3'd0;
   localparam logic [2:0] ST_MAP  = 3'd1;
   localparam logic [2:0] ST_IDLE = 3'd2;
   localparam logic [2:0] ST_FWD  = 3'd3;
   localparam logic [2:0] ST_WAIT = 3'd4;
   localparam logic [2:0] ST_RESP = 3'd5;

   // First byte past the 32-bit address space; regions are clipped here.
   localparam logic [33:0] c_addrLimit = 34'h1_0000_0000;

   logic [2:0]  r_state;
   logic [2:0]  w_nextState;

   // Per-node views of the flat port list
   logic [3:0]  w_nodeValid;
   logic [3:0]  w_nodeInfoValid;
   logic [3:0]  w_nodeBusy;
   logic [3:0]  w_nodeReq;
   logic [31:0] w_nodeMemSize [4];
   logic [31:0] w_nodeData    [4];

   // Address map: base is 33 bits wide so a region starting at 2^32 never hits
   logic [1:0]  r_mapIdx;
   logic        r_mapValid;
   logic [32:0] r_sum;
   logic [32:0] r_base [4];
   logic [33:0] r_end  [4];

   // Transaction context
   logic [1:0]  r_sel;
   logic        r_rw;
   logic [31:0] r_nodeAddr;
   logic [31:0] r_wrData;
   logic [31:0] r_respData;
   logic        r_respErr;

   logic        w_allReady;
   logic [31:0] w_mapSize;
   logic [33:0] w_mapEndRaw;
   logic [33:0] w_mapEnd;
   logic        w_hit;
   logic [1:0]  w_hitIdx;
   logic [31:0] w_hitLocal;
   logic        w_accept;
   logic        w_fwdIssue;
   logic        w_selResp;
   logic        w_timeout;

   assign w_nodeValid     = {iNODE3_VALID, iNODE2_VALID, iNODE1_VALID, iNODE0_VALID};
   assign w_nodeInfoValid = {iNODE3_INFO_VALID, iNODE2_INFO_VALID, iNODE1_INFO_VALID, iNODE0_INFO_VALID};
   assign w_nodeBusy      = {iNODE3_BUSY, iNODE2_BUSY, iNODE1_BUSY, iNODE0_BUSY};
   assign w_nodeReq       = {iNODE3_REQ, iNODE2_REQ, iNODE1_REQ, iNODE0_REQ};
   assign w_nodeMemSize[0] = iNODE0_MEMSIZE;
   assign w_nodeMemSize[1] = iNODE1_MEMSIZE;
   assign w_nodeMemSize[2] = iNODE2_MEMSIZE;
   assign w_nodeMemSize[3] = iNODE3_MEMSIZE;
   assign w_nodeData[0]    = iNODE0_DATA;
   assign w_nodeData[1]    = iNODE1_DATA;
   assign w_nodeData[2]    = iNODE2_DATA;
   assign w_nodeData[3]    = iNODE3_DATA;

   // An absent node never reports info, so only present nodes gate the map build.
   assign w_allReady  = &(~w_nodeValid | w_nodeInfoValid);
   assign w_mapSize   = w_nodeValid[r_mapIdx] ? w_nodeMemSize[r_mapIdx] : 32'h0;
   assign w_mapEndRaw = {1'b0, r_sum} + {2'b00, w_mapSize};
   assign w_mapEnd    = (w_mapEndRaw > c_addrLimit) ? c_addrLimit : w_mapEndRaw;

   assign w_accept   = (r_state == ST_IDLE) && iCPU_REQ;
   assign w_fwdIssue = (r_state == ST_FWD) && !w_nodeBusy[r_sel];
   assign w_selResp  = (r_state == ST_WAIT) && w_nodeReq[r_sel];
   assign w_hitLocal = iCPU_ADDR - r_base[w_hitIdx][31:0];

   // Region decode; scanning downward lets the lowest matching index win.
   always_comb begin
      w_hit    = 1'b0;
      w_hitIdx = 2'd0;
      for (int n = 3; n >= 0; n--) begin
         if (({1'b0, iCPU_ADDR} >= r_base[n]) && ({2'b00, iCPU_ADDR} < r_end[n])) begin
            w_hit    = 1'b1;
            w_hitIdx = 2'(n);
         end
      end
   end

`ifdef GCI_HUB_TIMEOUT_EN
   logic [7:0] r_toCnt;

   // WAIT-cycle counter, cleared as the request is issued (entry to WAIT).
   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         r_toCnt <= 8'd0;
      end else if (w_fwdIssue) begin
         r_toCnt <= 8'd0;
      end else if (r_state == ST_WAIT) begin
         r_toCnt <= r_toCnt + 8'd1;
      end
   end

   assign w_timeout = (r_state == ST_WAIT) && !w_selResp &&
                      (({1'b0, r_toCnt} + 9'd1) >= {1'b0, TIMEOUT});
`else
   logic w_unusedTimeout;
   assign w_unusedTimeout = ^TIMEOUT;
   assign w_timeout       = 1'b0;
`endif

   // State register
   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_INIT: if (w_allReady)             w_nextState = ST_MAP;
         ST_MAP:  if (r_mapIdx == 2'd3)       w_nextState = ST_IDLE;
         ST_IDLE: if (w_accept)               w_nextState = w_hit ? ST_FWD : ST_RESP;
         ST_FWD:  if (w_fwdIssue)             w_nextState = ST_WAIT;
         ST_WAIT: if (w_selResp || w_timeout) w_nextState = ST_RESP;
         ST_RESP: if (!iCPU_BUSY)             w_nextState = ST_IDLE;
         default:                             w_nextState = ST_INIT;
      endcase
   end

   // Map construction and transaction datapath
   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         r_mapIdx   <= 2'd0;
         r_mapValid <= 1'b0;
         r_sum      <= {1'b0, BASE_ADDR};
         for (int n = 0; n < 4; n++) begin
            r_base[n] <= 33'd0;
            r_end[n]  <= 34'd0;
         end
         r_sel      <= 2'd0;
         r_rw       <= 1'b0;
         r_nodeAddr <= 32'd0;
         r_wrData   <= 32'd0;
         r_respData <= 32'd0;
         r_respErr  <= 1'b0;
      end else begin
         if (r_state == ST_MAP) begin
            r_base[r_mapIdx] <= r_sum;
            r_end[r_mapIdx]  <= w_mapEnd;
            r_sum            <= r_sum + {1'b0, w_mapSize};
            r_mapIdx         <= r_mapIdx + 2'd1;
            if (r_mapIdx == 2'd3) begin
               r_mapValid <= 1'b1;
            end
         end
         if (w_accept) begin
            r_sel      <= w_hitIdx;
            r_rw       <= iCPU_RW;
            r_nodeAddr <= w_hitLocal;
            r_wrData   <= iCPU_DATA;
            r_respData <= 32'd0;
            r_respErr  <= !w_hit;
         end
         if (w_selResp) begin
            r_respData <= w_nodeData[r_sel];
            r_respErr  <= 1'b0;
         end else if (w_timeout) begin
            r_respData <= 32'hFFFF_FFFF;
            r_respErr  <= 1'b1;
         end
      end
   end

   // Output decode from state and held context
   always_comb begin
      oCPU_BUSY  = (r_state != ST_IDLE);
      oCPU_REQ   = (r_state == ST_RESP);
      oCPU_DATA  = (r_state == ST_RESP) ? r_respData : 32'd0;
      oCPU_ERR   = (r_state == ST_RESP) ? r_respErr  : 1'b0;
      oNODE0_REQ = w_fwdIssue && (r_sel == 2'd0);
      oNODE1_REQ = w_fwdIssue && (r_sel == 2'd1);
      oNODE2_REQ = w_fwdIssue && (r_sel == 2'd2);
      oNODE3_REQ = w_fwdIssue && (r_sel == 2'd3);
   end

   assign oMAP_VALID  = r_mapValid;
   assign oNODE0_RW   = r_rw;
   assign oNODE1_RW   = r_rw;
   assign oNODE2_RW   = r_rw;
   assign oNODE3_RW   = r_rw;
   assign oNODE0_ADDR = r_nodeAddr;
   assign oNODE1_ADDR = r_nodeAddr;
   assign oNODE2_ADDR = r_nodeAddr;
   assign oNODE3_ADDR = r_nodeAddr;
   assign oNODE0_DATA = r_wrData;
   assign oNODE1_DATA = r_wrData;
   assign oNODE2_DATA = r_wrData;
   assign oNODE3_DATA = r_wrData;
   assign oNODE0_BUSY = 1'b0;
   assign oNODE1_BUSY = 1'b0;
   assign oNODE2_BUSY = 1'b0;
   assign oNODE3_BUSY = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_gci_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gci_hub
//  Description : Directed self-checking bench for gci_hub (map build, routing,
//                unmapped error, backpressure, timeout/no-timeout, reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gci_hub;

   logic        iCLOCK, inRESET;
   logic        oMAP_VALID;
   logic        iCPU_REQ, oCPU_BUSY, iCPU_RW, oCPU_REQ, iCPU_BUSY, oCPU_ERR;
   logic [31:0] iCPU_ADDR, iCPU_DATA, oCPU_DATA;
   logic        iNODE0_VALID, iNODE0_INFO_VALID, oNODE0_REQ, iNODE0_BUSY, oNODE0_RW, iNODE0_REQ, oNODE0_BUSY;
   logic        iNODE1_VALID, iNODE1_INFO_VALID, oNODE1_REQ, iNODE1_BUSY, oNODE1_RW, iNODE1_REQ, oNODE1_BUSY;
   logic        iNODE2_VALID, iNODE2_INFO_VALID, oNODE2_REQ, iNODE2_BUSY, oNODE2_RW, iNODE2_REQ, oNODE2_BUSY;
   logic        iNODE3_VALID, iNODE3_INFO_VALID, oNODE3_REQ, iNODE3_BUSY, oNODE3_RW, iNODE3_REQ, oNODE3_BUSY;
   logic [31:0] iNODE0_MEMSIZE, oNODE0_ADDR, oNODE0_DATA, iNODE0_DATA;
   logic [31:0] iNODE1_MEMSIZE, oNODE1_ADDR, oNODE1_DATA, iNODE1_DATA;
   logic [31:0] iNODE2_MEMSIZE, oNODE2_ADDR, oNODE2_DATA, iNODE2_DATA;
   logic [31:0] iNODE3_MEMSIZE, oNODE3_ADDR, oNODE3_DATA, iNODE3_DATA;

   logic [3:0]  w_nodeReqVec;
   int          testsRun;
   int          testsFailed;

   assign w_nodeReqVec = {oNODE3_REQ, oNODE2_REQ, oNODE1_REQ, oNODE0_REQ};

   gci_hub #(
      .BASE_ADDR (32'h0000_0000),
      .TIMEOUT   (8'd8)
   ) dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .oMAP_VALID(oMAP_VALID),
      .iCPU_REQ(iCPU_REQ), .oCPU_BUSY(oCPU_BUSY), .iCPU_RW(iCPU_RW), .iCPU_ADDR(iCPU_ADDR),
      .iCPU_DATA(iCPU_DATA), .oCPU_REQ(oCPU_REQ), .iCPU_BUSY(iCPU_BUSY), .oCPU_DATA(oCPU_DATA),
      .oCPU_ERR(oCPU_ERR),
      .iNODE0_VALID(iNODE0_VALID), .iNODE0_INFO_VALID(iNODE0_INFO_VALID), .iNODE0_MEMSIZE(iNODE0_MEMSIZE),
      .oNODE0_REQ(oNODE0_REQ), .iNODE0_BUSY(iNODE0_BUSY), .oNODE0_RW(oNODE0_RW), .oNODE0_ADDR(oNODE0_ADDR),
      .oNODE0_DATA(oNODE0_DATA), .iNODE0_REQ(iNODE0_REQ), .oNODE0_BUSY(oNODE0_BUSY), .iNODE0_DATA(iNODE0_DATA),
      .iNODE1_VALID(iNODE1_VALID), .iNODE1_INFO_VALID(iNODE1_INFO_VALID), .iNODE1_MEMSIZE(iNODE1_MEMSIZE),
      .oNODE1_REQ(oNODE1_REQ), .iNODE1_BUSY(iNODE1_BUSY), .oNODE1_RW(oNODE1_RW), .oNODE1_ADDR(oNODE1_ADDR),
      .oNODE1_DATA(oNODE1_DATA), .iNODE1_REQ(iNODE1_REQ), .oNODE1_BUSY(oNODE1_BUSY), .iNODE1_DATA(iNODE1_DATA),
      .iNODE2_VALID(iNODE2_VALID), .iNODE2_INFO_VALID(iNODE2_INFO_VALID), .iNODE2_MEMSIZE(iNODE2_MEMSIZE),
      .oNODE2_REQ(oNODE2_REQ), .iNODE2_BUSY(iNODE2_BUSY), .oNODE2_RW(oNODE2_RW), .oNODE2_ADDR(oNODE2_ADDR),
      .oNODE2_DATA(oNODE2_DATA), .iNODE2_REQ(iNODE2_REQ), .oNODE2_BUSY(oNODE2_BUSY), .iNODE2_DATA(iNODE2_DATA),
      .iNODE3_VALID(iNODE3_VALID), .iNODE3_INFO_VALID(iNODE3_INFO_VALID), .iNODE3_MEMSIZE(iNODE3_MEMSIZE),
      .oNODE3_REQ(oNODE3_REQ), .iNODE3_BUSY(iNODE3_BUSY), .oNODE3_RW(oNODE3_RW), .oNODE3_ADDR(oNODE3_ADDR),
      .oNODE3_DATA(oNODE3_DATA), .iNODE3_REQ(iNODE3_REQ), .oNODE3_BUSY(oNODE3_BUSY), .iNODE3_DATA(iNODE3_DATA)
   );

   initial begin
      iCLOCK = 1'b0;
      forever #5 iCLOCK = ~iCLOCK;
   end

   // One full cycle: through the active edge, then back to the sampling edge.
   task automatic tick();
      @(posedge iCLOCK);
      @(negedge iCLOCK);
   endtask

   task automatic cpu_drive(input logic rw, input logic [31:0] addr, input logic [31:0] data);
      iCPU_REQ  = 1'b1;
      iCPU_RW   = rw;
      iCPU_ADDR = addr;
      iCPU_DATA = data;
   endtask

   task automatic node_resp(input int n, input logic req, input logic [31:0] data);
      case (n)
         0: begin iNODE0_REQ = req; iNODE0_DATA = data; end
         1: begin iNODE1_REQ = req; iNODE1_DATA = data; end
         2: begin iNODE2_REQ = req; iNODE2_DATA = data; end
         default: begin iNODE3_REQ = req; iNODE3_DATA = data; end
      endcase
   endtask

   task automatic test_reset();
      inRESET = 1'b0;
      tick();
      tick();
      #1;
      testsRun++; if (oMAP_VALID !== 1'b0) begin testsFailed++; $display("FAIL reset_map_valid got=%b exp=0", oMAP_VALID); end
      testsRun++; if (oCPU_BUSY !== 1'b1) begin testsFailed++; $display("FAIL reset_cpu_busy got=%b exp=1", oCPU_BUSY); end
      testsRun++; if (oCPU_REQ !== 1'b0) begin testsFailed++; $display("FAIL reset_cpu_req got=%b exp=0", oCPU_REQ); end
      testsRun++; if (w_nodeReqVec !== 4'b0000) begin testsFailed++; $display("FAIL reset_node_req got=%b exp=0000", w_nodeReqVec); end
      testsRun++; if ({oCPU_ERR, oCPU_DATA} !== 33'd0) begin testsFailed++; $display("FAIL reset_cpu_resp got=%b/%h exp=0/0", oCPU_ERR, oCPU_DATA); end
      testsRun++; if (oNODE0_ADDR !== 32'd0) begin testsFailed++; $display("FAIL reset_node_addr got=%h exp=0", oNODE0_ADDR); end
   endtask

   task automatic test_map();
      int cnt;
      iNODE1_INFO_VALID = 1'b0;
      inRESET = 1'b1;
      repeat (3) tick();
      #1;
      testsRun++; if ({oMAP_VALID, oCPU_BUSY} !== 2'b01) begin testsFailed++; $display("FAIL map_waits_info got=%b exp=01", {oMAP_VALID, oCPU_BUSY}); end
      iNODE1_INFO_VALID = 1'b1;
      cnt = 0;
      while (!oMAP_VALID && cnt < 20) begin
         tick();
         cnt++;
      end
      testsRun++; if (cnt < 4 || cnt > 5) begin testsFailed++; $display("FAIL map_latency got=%0d exp=4..5", cnt); end
      testsRun++; if (oCPU_BUSY !== 1'b0) begin testsFailed++; $display("FAIL map_idle_busy got=%b exp=0", oCPU_BUSY); end
   endtask

   task automatic test_read();
      cpu_drive(1'b0, 32'h0000_1004, 32'h0);
      tick();
      iCPU_REQ = 1'b0;
      #1;
      testsRun++; if (w_nodeReqVec !== 4'b0010) begin testsFailed++; $display("FAIL read_node_req got=%b exp=0010", w_nodeReqVec); end
      testsRun++; if ({oNODE1_RW, oNODE1_ADDR} !== {1'b0, 32'h4}) begin testsFailed++; $display("FAIL read_node_addr got=%b/%h exp=0/00000004", oNODE1_RW, oNODE1_ADDR); end
      tick();
      #1;
      testsRun++; if (w_nodeReqVec !== 4'b0000) begin testsFailed++; $display("FAIL read_req_pulse got=%b exp=0000", w_nodeReqVec); end
      node_resp(0, 1'b1, 32'hDEAD_BEEF);
      tick();
      node_resp(0, 1'b0, 32'h0);
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_BUSY} !== 2'b01) begin testsFailed++; $display("FAIL read_ignore_other got=%b exp=01", {oCPU_REQ, oCPU_BUSY}); end
      node_resp(1, 1'b1, 32'hCAFE_F00D);
      tick();
      node_resp(1, 1'b0, 32'h0);
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_ERR, oCPU_DATA} !== {2'b10, 32'hCAFE_F00D}) begin testsFailed++; $display("FAIL read_resp got=%b%b/%h exp=10/cafef00d", oCPU_REQ, oCPU_ERR, oCPU_DATA); end
      tick();
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_BUSY} !== 2'b00) begin testsFailed++; $display("FAIL read_done got=%b exp=00", {oCPU_REQ, oCPU_BUSY}); end
   endtask

   task automatic test_unmapped();
      // The map is frozen: growing node 3 now must not make 0x3100 hit.
      iNODE3_MEMSIZE = 32'h0000_1000;
      cpu_drive(1'b0, 32'h0000_3100, 32'h0);
      tick();
      iCPU_REQ = 1'b0;
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_ERR, oCPU_DATA} !== {2'b11, 32'h0}) begin testsFailed++; $display("FAIL unmapped_resp got=%b%b/%h exp=11/00000000", oCPU_REQ, oCPU_ERR, oCPU_DATA); end
      testsRun++; if (w_nodeReqVec !== 4'b0000) begin testsFailed++; $display("FAIL unmapped_node_req got=%b exp=0000", w_nodeReqVec); end
      tick();
      #1;
      testsRun++; if (oCPU_REQ !== 1'b0) begin testsFailed++; $display("FAIL unmapped_done got=%b exp=0", oCPU_REQ); end
      iNODE3_MEMSIZE = 32'h0000_0100;
   endtask

   task automatic test_boundary();
      logic [31:0] addrTab  [6] = '{32'h0, 32'h0FFF, 32'h1000, 32'h2FFF, 32'h3000, 32'h30FF};
      int          nodeTab  [6] = '{0, 0, 1, 1, 3, 3};
      logic [31:0] localTab [6] = '{32'h0, 32'h0FFF, 32'h0, 32'h1FFF, 32'h0, 32'hFF};
      logic [3:0]  expVec;
      logic [31:0] respData;
      for (int i = 0; i < 6; i++) begin
         expVec   = 4'b0001 << nodeTab[i];
         respData = addrTab[i] ^ 32'h5A5A_0000;
         cpu_drive(1'b0, addrTab[i], 32'h0);
         tick();
         iCPU_REQ = 1'b0;
         #1;
         testsRun++; if ({w_nodeReqVec, oNODE2_ADDR} !== {expVec, localTab[i]}) begin testsFailed++; $display("FAIL boundary_route addr=%h got=%b/%h exp=%b/%h", addrTab[i], w_nodeReqVec, oNODE2_ADDR, expVec, localTab[i]); end
         tick();
         node_resp(nodeTab[i], 1'b1, respData);
         tick();
         node_resp(nodeTab[i], 1'b0, 32'h0);
         #1;
         testsRun++; if ({oCPU_REQ, oCPU_ERR, oCPU_DATA} !== {2'b10, respData}) begin testsFailed++; $display("FAIL boundary_resp addr=%h got=%b%b/%h exp=10/%h", addrTab[i], oCPU_REQ, oCPU_ERR, oCPU_DATA, respData); end
         tick();
      end
   endtask

   task automatic test_back_to_back_backpressure();
      iNODE3_BUSY = 1'b1;
      cpu_drive(1'b1, 32'h0000_3010, 32'h0000_0055);
      tick();
      iCPU_REQ = 1'b0;
      #1;
      testsRun++; if ({oNODE3_RW, oNODE3_ADDR, oNODE3_DATA} !== {1'b1, 32'h10, 32'h55}) begin testsFailed++; $display("FAIL bp_node_fields got=%b/%h/%h exp=1/00000010/00000055", oNODE3_RW, oNODE3_ADDR, oNODE3_DATA); end
      for (int i = 0; i < 3; i++) begin
         testsRun++; if (w_nodeReqVec !== 4'b0000) begin testsFailed++; $display("FAIL bp_hold_req cyc=%0d got=%b exp=0000", i, w_nodeReqVec); end
         tick();
         #1;
      end
      iNODE3_BUSY = 1'b0;
      #1;
      testsRun++; if (w_nodeReqVec !== 4'b1000) begin testsFailed++; $display("FAIL bp_release_req got=%b exp=1000", w_nodeReqVec); end
      tick();
      iCPU_BUSY = 1'b1;
      node_resp(3, 1'b1, 32'h0);
      tick();
      node_resp(3, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         testsRun++; if ({oCPU_REQ, oCPU_ERR, oCPU_DATA} !== {2'b10, 32'h0}) begin testsFailed++; $display("FAIL bp_resp_hold cyc=%0d got=%b%b/%h exp=10/00000000", i, oCPU_REQ, oCPU_ERR, oCPU_DATA); end
         if (i == 2) iCPU_BUSY = 1'b0;
         tick();
      end
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_BUSY} !== 2'b00) begin testsFailed++; $display("FAIL bp_done got=%b exp=00", {oCPU_REQ, oCPU_BUSY}); end
   endtask

   task automatic test_timeout();
      int cnt;
      cpu_drive(1'b0, 32'h0000_0010, 32'h0);
      tick();
      iCPU_REQ = 1'b0;
`ifdef GCI_HUB_TIMEOUT_EN
      // Issue cycle, then 8 WAIT cycles before the error response appears.
      cnt = 0;
      while (!oCPU_REQ && cnt < 50) begin
         tick();
         cnt++;
      end
      #1;
      testsRun++; if (cnt !== 9) begin testsFailed++; $display("FAIL timeout_latency got=%0d exp=9", cnt); end
      testsRun++; if ({oCPU_REQ, oCPU_ERR, oCPU_DATA} !== {2'b11, 32'hFFFF_FFFF}) begin testsFailed++; $display("FAIL timeout_resp got=%b%b/%h exp=11/ffffffff", oCPU_REQ, oCPU_ERR, oCPU_DATA); end
      tick();
      node_resp(0, 1'b1, 32'h1234_5678);
      tick();
      node_resp(0, 1'b0, 32'h0);
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_BUSY} !== 2'b00) begin testsFailed++; $display("FAIL timeout_late_ignored got=%b exp=00", {oCPU_REQ, oCPU_BUSY}); end
`else
      cnt = 0;
      repeat (20) begin
         tick();
         if (oCPU_REQ !== 1'b0) cnt++;
      end
      testsRun++; if (cnt !== 0) begin testsFailed++; $display("FAIL nowait_hold got=%0d exp=0", cnt); end
      node_resp(0, 1'b1, 32'h1234_5678);
      tick();
      node_resp(0, 1'b0, 32'h0);
      #1;
      testsRun++; if ({oCPU_REQ, oCPU_ERR, oCPU_DATA} !== {2'b10, 32'h1234_5678}) begin testsFailed++; $display("FAIL nowait_resp got=%b%b/%h exp=10/12345678", oCPU_REQ, oCPU_ERR, oCPU_DATA); end
      tick();
`endif
   endtask

   task automatic test_reset_midwait();
      int cnt;
      cpu_drive(1'b0, 32'h0000_1000, 32'h0);
      tick();
      iCPU_REQ = 1'b0;
      tick();
      inRESET = 1'b0;
      tick();
      #1;
      testsRun++; if ({oCPU_REQ, oMAP_VALID, oCPU_BUSY} !== 3'b001) begin testsFailed++; $display("FAIL midreset_state got=%b exp=001", {oCPU_REQ, oMAP_VALID, oCPU_BUSY}); end
      node_resp(1, 1'b1, 32'h0000_0BAD);
      tick();
      node_resp(1, 1'b0, 32'h0);
      inRESET = 1'b1;
      #1;
      testsRun++; if (oCPU_REQ !== 1'b0) begin testsFailed++; $display("FAIL midreset_no_resp got=%b exp=0", oCPU_REQ); end
      cnt = 0;
      while (!oMAP_VALID && cnt < 20) begin
         tick();
         cnt++;
      end
      testsRun++; if (cnt < 4 || cnt > 5) begin testsFailed++; $display("FAIL midreset_remap got=%0d exp=4..5", cnt); end
      cpu_drive(1'b0, 32'h0000_3000, 32'h0);
      tick();
      iCPU_REQ = 1'b0;
      #1;
      testsRun++; if (w_nodeReqVec !== 4'b1000) begin testsFailed++; $display("FAIL midreset_route got=%b exp=1000", w_nodeReqVec); end
      tick();
      node_resp(3, 1'b1, 32'h0);
      tick();
      node_resp(3, 1'b0, 32'h0);
      tick();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      inRESET   = 1'b0;
      iCPU_REQ  = 1'b0;
      iCPU_RW   = 1'b0;
      iCPU_ADDR = 32'h0;
      iCPU_DATA = 32'h0;
      iCPU_BUSY = 1'b0;
      iNODE0_VALID = 1'b1; iNODE0_INFO_VALID = 1'b1; iNODE0_MEMSIZE = 32'h0000_1000;
      iNODE1_VALID = 1'b1; iNODE1_INFO_VALID = 1'b1; iNODE1_MEMSIZE = 32'h0000_2000;
      iNODE2_VALID = 1'b0; iNODE2_INFO_VALID = 1'b0; iNODE2_MEMSIZE = 32'h0000_5000;
      iNODE3_VALID = 1'b1; iNODE3_INFO_VALID = 1'b1; iNODE3_MEMSIZE = 32'h0000_0100;
      iNODE0_BUSY = 1'b0; iNODE0_REQ = 1'b0; iNODE0_DATA = 32'h0;
      iNODE1_BUSY = 1'b0; iNODE1_REQ = 1'b0; iNODE1_DATA = 32'h0;
      iNODE2_BUSY = 1'b0; iNODE2_REQ = 1'b0; iNODE2_DATA = 32'h0;
      iNODE3_BUSY = 1'b0; iNODE3_REQ = 1'b0; iNODE3_DATA = 32'h0;
      @(negedge iCLOCK);
      test_reset();
      test_map();
      test_read();
      test_unmapped();
      test_boundary();
      test_back_to_back_backpressure();
      test_timeout();
      test_reset_midwait();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
`default_nettype wire
